fpu_normalizer: RTL
===================

Name: fpu_normalizer

Overview:
- Post-add/subtract normalise-and-round stage.
- Sits directly downstream of the FPU adder datapath.
- Consumes an unnormalised sign/exponent/wide-mantissa result.
- Produces the packed 32-bit word (sign[31], exponent[30:20], fraction[19:0]) plus a status code.
- Valid/ready handshakes on both sides; left normalisation is iterative, one bit per cycle.

Parameters:
- EXP_W, 11: exponent field width.
- FRAC_W, 20: fraction field width.
- BIAS, 1023: exponent bias.

Ports:
- m_clk  in  1: clock.
- m_reset  in  1: synchronous, active-high reset.
- m_inValid  in  1: upstream result valid.
- m_inReady  out  1: block can accept a result.
- m_inSign  in  1: result sign.
- m_inExp  in  EXP_W+2: signed biased exponent; may be ≤0 or ≥2^EXP_W−1.
- m_inMant  in  FRAC_W+5: raw mantissa, laid out as:
  - [FRAC_W+4] carry
  - [FRAC_W+3] hidden
  - [FRAC_W+2:3] fraction
  - [2] guard
  - [1] round
  - [0] sticky
- m_outValid  out  1: packed result valid.
- m_outReady  in  1: downstream accepts.
- m_dataOut  out  32: packed result.
- m_statusOut  out  eStatus: EXACT / OVEFLOW / UNDERFLOW / INEXACT.

Behaviour:
- Clocking and reset:
  - One clock (m_clk); reset synchronous and active-high (m_reset).
  - Reset returns state to IDLE; m_outValid=0, m_dataOut=0, m_statusOut=EXACT.
  - m_inReady is 1 only in IDLE, so it reads 1 after reset.
  - Reset mid-operation discards the in-flight result; no output is produced for it.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE:
  - Accept on m_inValid && m_inReady; latch sign, exponent and mantissa.
  - Mantissa ==0 → result = signed zero, status EXACT, go DONE.
  - Carry bit set → right shift 1, LSB ORed into sticky, exp+1, go ROUND.
  - Hidden bit set → go ROUND.
  - Otherwise → go SHIFT.
- SHIFT (one bit per cycle):
  - Left shift 1, exp−1.
  - When the hidden bit becomes 1 → go ROUND.
  - Max FRAC_W+3 iterations.
- ROUND:
  - Round to nearest, ties to even, using G/R/S.
  - Increment carry-out → right shift 1, exp+1.
  - Final exp ≥ 2^EXP_W−1 → {sign, all-ones exponent, zero fraction}, OVEFLOW.
  - Final exp ≤ 0 → signed zero, UNDERFLOW (no subnormals; flush).
  - Any G/R/S nonzero → INEXACT; else EXACT.
  - Priority: OVEFLOW > UNDERFLOW > INEXACT > EXACT.
  - Register outputs; go DONE.
- DONE:
  - m_outValid=1; m_dataOut and m_statusOut held stable until m_outReady=1.
  - On that handshake, m_outValid=0 next cycle and state returns to IDLE.
  - No bypass: a new input is accepted only in IDLE, so throughput is one result per 3+k cycles.
- Latency: m_outValid rises 2+k cycles after the accept edge, where k = left-shift count (k=0 for normalised or carry input).
- Input exponent already ≤0 with nonzero mantissa → UNDERFLOW.

Optional Feature:
- Macro: FPU_NORM_FASTSHIFT_EN.
- Defined:
  - SHIFT state removed.
  - A combinational leading-zero count plus barrel shift is applied at accept.
  - Latency is fixed at 2 cycles for all inputs.
  - Results and status bit-identical to the iterative path.
- Undefined: iterative behaviour above.

Decomposition:
- Package fpu_pkg:
  - eStatus
  - EXP_W, FRAC_W, BIAS
  - raw mantissa width FRAC_W+5
  - FSM state enum
- Sub-module fpu_lzc:
  - Parameterised leading-zero counter.
  - Instantiated only under FPU_NORM_FASTSHIFT_EN.

Test Plan:
1. Normalised input → 0x3FF00000, EXACT.
   - Stimulus: sign 0, exp 1023, mant 0x0800000.
   - Response: m_outValid exactly 2 cycles after accept.
2. Carry input → 0x40000000, EXACT, latency 2.
   - Stimulus: exp 1023, mant 0x1000000.
3. Left shift by 2 → 0x3FD00000, EXACT, latency 4 (2 with FASTSHIFT).
   - Stimulus: exp 1023, mant 0x0200000.
4. Rounding, INEXACT in both cases:
   - Tie to even: exp 1023, mant 0x0800004 → 0x3FF00000.
   - Odd LSB rounds up: mant 0x080000C → 0x3FF00002.
5. Overflow and underflow:
   - exp 2046, mant 0x1000000, sign 1 → 0xFFF00000, OVEFLOW.
   - exp 1, mant 0x0400000 → 0x00000000, UNDERFLOW.
6. Backpressure and reset:
   - m_outReady=0 for 5 cycles in DONE → outputs stable, m_inReady=0.
   - m_reset pulsed during SHIFT → m_outValid=0 next cycle, m_inReady=1, no output emitted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared widths, status codes and FSM states for the FPU normalise/round stage.
package fpu_pkg;

    localparam int EXP_W   = 11;
    localparam int FRAC_W  = 20;
    localparam int BIAS    = 1023;
    localparam int MANT_W  = FRAC_W + 5;
    // The all-ones exponent is reserved for overflow (infinity).
    localparam int EXP_MAX = 2 * BIAS + 1;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        OVEFLOW   = 2'd1,
        UNDERFLOW = 2'd2,
        INEXACT   = 2'd3
    } eStatus;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } norm_state_e;

endpackage

// File: rtl/fpu_lzc.sv
// Parameterised leading-zero counter; count equals W when data is all zeros.
module fpu_lzc #(
    parameter int W     = 24,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     data,
    output logic [CNT_W-1:0] count
);

    // NOTE: count gets its default before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        count = CNT_W'(W);
        // Ascending scan: the highest set bit is the last one to write.
        for (int i = 0; i < W; i++) begin
            if (data[i]) count = CNT_W'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_normalizer.sv
// Normalise-and-round stage behind the FPU adder. Define FPU_NORM_FASTSHIFT_EN
// to replace the bit-serial left shift with an LZC + barrel shift at accept.
module fpu_normalizer
    import fpu_pkg::*;
(
    input  logic                    m_clk,
    input  logic                    m_reset,
    input  logic                    m_inValid,
    output logic                    m_inReady,
    input  logic                    m_inSign,
    input  logic signed [EXP_W+1:0] m_inExp,
    input  logic [MANT_W-1:0]       m_inMant,
    output logic                    m_outValid,
    input  logic                    m_outReady,
    output logic [31:0]             m_dataOut,
    output eStatus                  m_statusOut
);

    // Internal exponent has headroom for carry and round increments and for
    // the full left-shift range without wrapping.
    localparam int EXP_IW = EXP_W + 3;
    localparam int SIG_W  = FRAC_W + 4;
    localparam logic signed [EXP_IW-1:0] EXP_OVF  = EXP_IW'(EXP_MAX);
    localparam logic signed [EXP_IW-1:0] EXP_ZERO = '0;

    norm_state_e              state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EXP_IW-1:0] exp_q, exp_d;
    logic [SIG_W-1:0]         mant_q, mant_d;
    logic                     uf_q, uf_d;
    logic [31:0]              data_q, data_d;
    eStatus                   status_q, status_d;

    logic signed [EXP_IW-1:0] in_exp;
    assign in_exp = EXP_IW'(m_inExp);

`ifdef FPU_NORM_FASTSHIFT_EN
    logic [$clog2(SIG_W+1)-1:0] lz;

    fpu_lzc #(.W(SIG_W)) u_lzc (
        .data  (m_inMant[SIG_W-1:0]),
        .count (lz)
    );
`endif

    // Round to nearest, ties to even, on the normalised hidden.fraction|G|R|S.
    logic                     inexact, round_up, rnd_carry;
    logic [FRAC_W+1:0]        rounded;
    logic [FRAC_W-1:0]        frac_fin;
    logic signed [EXP_IW-1:0] exp_fin;

    always_comb begin
        inexact   = |mant_q[2:0];
        round_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        rounded   = {1'b0, mant_q[SIG_W-1:3]} + (FRAC_W+2)'(round_up);
        rnd_carry = rounded[FRAC_W+1];
        frac_fin  = rnd_carry ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
        exp_fin   = exp_q + EXP_IW'(rnd_carry);
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        uf_d     = uf_q;
        data_d   = data_q;
        status_d = status_q;

        case (state_q)
            IDLE: begin
                if (m_inValid) begin
                    sign_d = m_inSign;
                    exp_d  = in_exp;
                    mant_d = m_inMant[SIG_W-1:0];
                    uf_d   = (in_exp <= EXP_ZERO);
                    if (m_inMant == '0) begin
                        data_d   = {m_inSign, 31'b0};
                        status_d = EXACT;
                        state_d  = DONE;
                    end else if (m_inMant[MANT_W-1]) begin
                        mant_d  = {m_inMant[MANT_W-1:2], |m_inMant[1:0]};
                        exp_d   = in_exp + EXP_IW'(1);
                        state_d = ROUND;
                    end else if (m_inMant[SIG_W-1]) begin
                        state_d = ROUND;
                    end else begin
`ifdef FPU_NORM_FASTSHIFT_EN
                        mant_d  = m_inMant[SIG_W-1:0] << lz;
                        exp_d   = in_exp - EXP_IW'(lz);
                        state_d = ROUND;
`else
                        state_d = SHIFT;
`endif
                    end
                end
            end
`ifndef FPU_NORM_FASTSHIFT_EN
            SHIFT: begin
                mant_d = mant_q << 1;
                exp_d  = exp_q - EXP_IW'(1);
                if (mant_q[SIG_W-2]) state_d = ROUND;
            end
`endif
            ROUND: begin
                if (exp_fin >= EXP_OVF) begin
                    data_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    status_d = OVEFLOW;
                end else if (uf_q || exp_fin <= EXP_ZERO) begin
                    data_d   = {sign_q, 31'b0};
                    status_d = UNDERFLOW;
                end else begin
                    data_d   = {sign_q, exp_fin[EXP_W-1:0], frac_fin};
                    status_d = inexact ? INEXACT : EXACT;
                end
                state_d = DONE;
            end
            DONE: begin
                if (m_outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: flops update with non-blocking assignments so each one samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge m_clk) begin
        if (m_reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            status_q <= EXACT;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    // NOTE: the working registers are deliberately unreset; they are always
    // loaded on accept before anything reads them.
    always_ff @(posedge m_clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        mant_q <= mant_d;
        uf_q   <= uf_d;
    end

    assign m_inReady   = (state_q == IDLE);
    assign m_outValid  = (state_q == DONE);
    assign m_dataOut   = data_q;
    assign m_statusOut = status_q;

endmodule
